// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared L1-D snoop bus between ooo_d and ppl_d caches.
// Optional macro SNOOP_TIMEOUT_EN adds a forced timeout response (code 11) after TIMEOUT_CYCLES.
module snoop_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ooo_d_bus_query,
  input  logic [ADDR_WIDTH-1:0] ooo_d_address,
  input  logic [1:0]            ooo_d_command,
  input  logic [DATA_WIDTH-1:0] ooo_d_data,
  input  logic                  ppl_d_bus_query,
  input  logic [ADDR_WIDTH-1:0] ppl_d_address,
  input  logic [1:0]            ppl_d_command,
  input  logic [DATA_WIDTH-1:0] ppl_d_data,
  output logic                  ooo_d_grant,
  output logic                  ppl_d_grant,
  output logic                  snoop_valid,
  output logic                  snoop_target,
  output logic [ADDR_WIDTH-1:0] snoop_address,
  output logic [1:0]            snoop_command,
  output logic [DATA_WIDTH-1:0] snoop_data,
  input  logic                  snoop_resp_valid,
  input  logic                  snoop_resp_hit,
  input  logic [DATA_WIDTH-1:0] snoop_resp_data,
  output logic [1:0]            ooo_d_resp,
  output logic [1:0]            ppl_d_resp,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  bus_ready
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] CMD_FLUSH = 2'b11;
  localparam logic [1:0] RSP_HIT   = 2'b01;
  localparam logic [1:0] RSP_MISS  = 2'b10;
  localparam logic [1:0] RSP_TMO   = 2'b11;

  state_t                state, state_n;
  logic                  owner;       // 0 = ooo_d, 1 = ppl_d
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            cmd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            rsp_code;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  any_query, win, wait_ph, tmo;

  assign any_query = ooo_d_bus_query | ppl_d_bus_query;
  // Tie goes to whoever did not win last time; a lone query always wins.
  assign win       = (ooo_d_bus_query & ppl_d_bus_query) ? ~last_grant : ppl_d_bus_query;
  assign wait_ph   = (state == S_CMD) || (state == S_WAIT);

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 tmo_cnt <= '0;
    else if (state == S_IDLE) tmo_cnt <= '0;
    else if (wait_ph)         tmo_cnt <= tmo_cnt + CW'(1);
  end

  // Fires in the cycle the count would reach TIMEOUT_CYCLES, so RESP lands exactly
  // TIMEOUT_CYCLES cycles after CMD entry.
  assign tmo = wait_ph && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (any_query) state_n = S_CMD;
      S_CMD:  state_n = (snoop_resp_valid || tmo) ? S_RESP : S_WAIT;
      S_WAIT: if (snoop_resp_valid || tmo) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      rsp_code   <= '0;
      rsp_data   <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && any_query) begin
        owner      <= win;
        last_grant <= win;
        addr_q     <= win ? ppl_d_address : ooo_d_address;
        cmd_q      <= win ? ppl_d_command : ooo_d_command;
        if (win) data_q <= (ppl_d_command == CMD_FLUSH) ? ppl_d_data : '0;
        else     data_q <= (ooo_d_command == CMD_FLUSH) ? ooo_d_data : '0;
      end
      // A real response beats a timeout in the same cycle.
      if (wait_ph && snoop_resp_valid) begin
        rsp_code <= snoop_resp_hit ? RSP_HIT : RSP_MISS;
        rsp_data <= (snoop_resp_hit && !cmd_q[1]) ? snoop_resp_data : '0;
      end else if (tmo) begin
        rsp_code <= RSP_TMO;
        rsp_data <= '0;
      end
    end
  end

  assign bus_ready     = (state == S_IDLE);
  assign ooo_d_grant   = !bus_ready && !owner;
  assign ppl_d_grant   = !bus_ready && owner;
  assign snoop_valid   = (state == S_CMD);
  assign snoop_target  = !bus_ready && !owner;
  assign snoop_address = addr_q;
  assign snoop_command = cmd_q;
  assign snoop_data    = data_q;
  assign ooo_d_resp    = (state == S_RESP && !owner) ? rsp_code : 2'b00;
  assign ppl_d_resp    = (state == S_RESP && owner)  ? rsp_code : 2'b00;
  assign resp_data     = (state == S_RESP) ? rsp_data : '0;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomized transaction-level bench for snoop_bus_arbiter against a round-robin reference model.
module tb_snoop_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          ooo_d_bus_query, ppl_d_bus_query;
  logic [AW-1:0] ooo_d_address, ppl_d_address;
  logic [1:0]    ooo_d_command, ppl_d_command;
  logic [DW-1:0] ooo_d_data, ppl_d_data;
  logic          ooo_d_grant, ppl_d_grant, snoop_valid, snoop_target;
  logic [AW-1:0] snoop_address;
  logic [1:0]    snoop_command;
  logic [DW-1:0] snoop_data;
  logic          snoop_resp_valid, snoop_resp_hit;
  logic [DW-1:0] snoop_resp_data;
  logic [1:0]    ooo_d_resp, ppl_d_resp;
  logic [DW-1:0] resp_data;
  logic          bus_ready;

  int total = 0;
  int bad   = 0;
  bit last_ppl;  // model: previous winner was ppl_d

`ifdef SNOOP_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1 << 30;
`endif

  snoop_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ooo_d_bus_query(ooo_d_bus_query), .ooo_d_address(ooo_d_address),
    .ooo_d_command(ooo_d_command), .ooo_d_data(ooo_d_data),
    .ppl_d_bus_query(ppl_d_bus_query), .ppl_d_address(ppl_d_address),
    .ppl_d_command(ppl_d_command), .ppl_d_data(ppl_d_data),
    .ooo_d_grant(ooo_d_grant), .ppl_d_grant(ppl_d_grant),
    .snoop_valid(snoop_valid), .snoop_target(snoop_target),
    .snoop_address(snoop_address), .snoop_command(snoop_command), .snoop_data(snoop_data),
    .snoop_resp_valid(snoop_resp_valid), .snoop_resp_hit(snoop_resp_hit),
    .snoop_resp_data(snoop_resp_data),
    .ooo_d_resp(ooo_d_resp), .ppl_d_resp(ppl_d_resp), .resp_data(resp_data),
    .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, bus_ready, 1'b1);
    chk({tag, ".grants"}, {ooo_d_grant, ppl_d_grant}, 2'b00);
    chk({tag, ".svalid"}, snoop_valid, 1'b0);
    chk({tag, ".resps"}, {ooo_d_resp, ppl_d_resp}, 4'b0);
    chk({tag, ".rdata"}, resp_data, '0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // d = cycles after CMD entry at which the snooper answers.
  task automatic run_txn(input bit qo, input bit qp,
                         input logic [AW-1:0] ao, input logic [1:0] co, input logic [DW-1:0] dao,
                         input logic [AW-1:0] ap, input logic [1:0] cp, input logic [DW-1:0] dap,
                         input int d, input bit hit, input logic [DW-1:0] sd);
    bit w;
    logic [1:0] ecmd, ecode;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata, erdata;
    int last;
    w      = (qo && qp) ? !last_ppl : qp;
    last_ppl = w;
    eaddr  = w ? ap : ao;
    ecmd   = w ? cp : co;
    edata  = (ecmd == 2'b11) ? (w ? dap : dao) : '0;
    if (d >= TMO) begin
      ecode = 2'b11; erdata = '0;
    end else begin
      ecode  = hit ? 2'b01 : 2'b10;
      erdata = (hit && ecmd < 2) ? sd : '0;
    end

    ooo_d_bus_query = qo; ooo_d_address = ao; ooo_d_command = co; ooo_d_data = dao;
    ppl_d_bus_query = qp; ppl_d_address = ap; ppl_d_command = cp; ppl_d_data = dap;
    snoop_resp_valid = 1'($urandom % 2);  // ignored while idle
    snoop_resp_hit   = 1'b1;
    snoop_resp_data  = rnd256();
    @(negedge clk);
    chk("cmd.grant", {ooo_d_grant, ppl_d_grant}, w ? 2'b01 : 2'b10);
    chk("cmd.svalid", snoop_valid, 1'b1);
    chk("cmd.target", snoop_target, !w);
    chk("cmd.addr", snoop_address, eaddr);
    chk("cmd.cmd", snoop_command, ecmd);
    chk("cmd.data", snoop_data, edata);
    chk("cmd.ready", bus_ready, 1'b0);
    chk("cmd.resps", {ooo_d_resp, ppl_d_resp}, 4'b0);

    last = (d < TMO) ? d : TMO - 1;
    for (int i = 0; i <= last; i++) begin
      if (i > 0) begin
        chk("wait.svalid", snoop_valid, 1'b0);
        chk("wait.grant", {ooo_d_grant, ppl_d_grant}, w ? 2'b01 : 2'b10);
        chk("wait.resps", {ooo_d_resp, ppl_d_resp}, 4'b0);
        chk("wait.ready", bus_ready, 1'b0);
      end
      snoop_resp_valid = (i == d);
      snoop_resp_hit   = hit;
      snoop_resp_data  = sd;
      @(negedge clk);
    end

    chk("resp.ooo", ooo_d_resp, w ? 2'b00 : ecode);
    chk("resp.ppl", ppl_d_resp, w ? ecode : 2'b00);
    chk("resp.data", resp_data, erdata);
    chk("resp.grant", {ooo_d_grant, ppl_d_grant}, w ? 2'b01 : 2'b10);
    ooo_d_bus_query  = 1'b0;
    ppl_d_bus_query  = 1'b0;
    snoop_resp_valid = 1'($urandom % 2);  // ignored in RESP
    snoop_resp_data  = rnd256();
    @(negedge clk);
    chk_idle("post");
    snoop_resp_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] a5, dead;
    a5   = {32{8'hA5}};
    dead = {8{32'hDEADBEEF}};
    rst = 1'b0;
    ooo_d_bus_query = 0; ppl_d_bus_query = 0;
    ooo_d_address = '0; ppl_d_address = '0; ooo_d_command = '0; ppl_d_command = '0;
    ooo_d_data = '0; ppl_d_data = '0;
    snoop_resp_valid = 0; snoop_resp_hit = 0; snoop_resp_data = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset.saddr", snoop_address, '0);
    chk("reset.target", snoop_target, 1'b0);
    rst = 1'b1;
    last_ppl = 1'b1;
    @(negedge clk);

    // directed: ooo BusRd hit, ppl BusRdX miss, ooo Flush hit/miss, long wait
    run_txn(1, 0, 32'h0000_1200, 2'b00, '0, '0, 2'b00, '0, 0, 1, a5);
    run_txn(0, 1, '0, 2'b00, '0, 32'h0000_3400, 2'b01, '0, 2, 0, a5);
    run_txn(1, 0, 32'h0000_5600, 2'b11, dead, '0, 2'b00, '0, 1, 1, a5);
    run_txn(1, 0, 32'h0000_5640, 2'b11, dead, '0, 2'b00, '0, 0, 0, a5);
    run_txn(0, 1, '0, 2'b00, '0, 32'h0000_7800, 2'b10, dead, 3, 1, a5);
    run_txn(0, 1, '0, 2'b00, '0, 32'h0000_9A00, 2'b00, '0, 20, 1, a5);
    run_txn(1, 0, 32'h0000_9B00, 2'b00, '0, '0, 2'b00, '0, 15, 1, a5);

    for (int n = 0; n < 40; n++) begin
      int r, d;
      r = $urandom_range(1, 3);
      d = ($urandom % 10 == 0) ? 18 : $urandom_range(0, 5);
      run_txn(r[0], r[1], $urandom, 2'($urandom), rnd256(),
              $urandom, 2'($urandom), rnd256(), d, 1'($urandom), rnd256());
    end

    // async reset while waiting on the snooper
    ooo_d_bus_query = 1; ooo_d_address = 32'hABCD_0000; ooo_d_command = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst.grant", ooo_d_grant, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_idle("rst_async");
    chk("rst_async.saddr", snoop_address, '0);
    ooo_d_bus_query = 0;
    @(negedge clk);
    rst = 1'b1;
    last_ppl = 1'b1;
    snoop_resp_valid = 1'b1;  // stale answer after reset must not produce a response
    snoop_resp_hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("after_rst");
      snoop_resp_valid = 1'b0;
    end

    // both held from reset: strict alternation starting with ooo_d
    for (int n = 0; n < 4; n++)
      run_txn(1, 1, 32'h100 + n, 2'b00, '0, 32'h200 + n, 2'b01, '0, n, 1, rnd256());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
